pipe_control_unit: RTL and testbench

Parametrised RV32I(+M) control unit for the 5-stage pipeline. Decodes the instruction in Decode and registers the control word into the Execute stage. Handles flush bubbles and sequences multi-cycle MUL/DIV ops by holding the E control register and raising a stall to the hazard unit. Extends the 3-bit ALU control to 4 bits and adds jalr, lui, auipc and illegal-op detection.

---
 rtl/pipe_control_unit.sv | 149 ++++++++++++++
 tb/tb_pipe_control_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// RV32I(+M) control unit: decodes in D, registers the control word into E,
// and holds E while a multi-cycle M op occupies the MDU.
module pipe_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter int IMM_SRC_W  = 3,
  parameter int ENABLE_M   = 1,
  parameter int MDU_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  validD,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  flushE,
  output logic [IMM_SRC_W-1:0]  imm_srcD,
  output logic                  reg_wrE,
  output logic [1:0]            result_srcE,
  output logic                  mem_wrE,
  output logic                  jumpE,
  output logic                  jalrE,
  output logic                  branchE,
  output logic [ALU_CTRL_W-1:0] ALU_ctrlE,
  output logic                  ALU_srcE,
  output logic                  ALU_srcAE,
  output logic                  illegalE,
  output logic                  mdu_startE,
  output logic [2:0]            mdu_funct3E,
  output logic                  mdu_stall
);

  localparam int CNT_W = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

  logic                  d_reg_wr, d_mem_wr, d_jump, d_jalr, d_branch;
  logic                  d_alu_src, d_alu_srca, d_is_m, legal;
  logic [1:0]            d_result_src;
  logic [ALU_CTRL_W-1:0] d_alu_ctrl;
  logic [2:0]            d_mdu_f3;
  logic [CNT_W-1:0]      cnt_reg;

  function automatic logic [ALU_CTRL_W-1:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? ALU_CTRL_W'(1) : ALU_CTRL_W'(0);
      3'b001:  alu_fn = ALU_CTRL_W'(7);
      3'b010:  alu_fn = ALU_CTRL_W'(5);
      3'b011:  alu_fn = ALU_CTRL_W'(6);
      3'b100:  alu_fn = ALU_CTRL_W'(4);
      3'b101:  alu_fn = alt ? ALU_CTRL_W'(9) : ALU_CTRL_W'(8);
      3'b110:  alu_fn = ALU_CTRL_W'(3);
      default: alu_fn = ALU_CTRL_W'(2);
    endcase
  endfunction

  always_comb begin
    imm_srcD     = '0;
    d_reg_wr     = 1'b0;
    d_result_src = 2'b00;
    d_mem_wr     = 1'b0;
    d_jump       = 1'b0;
    d_jalr       = 1'b0;
    d_branch     = 1'b0;
    d_alu_ctrl   = '0;
    d_alu_src    = 1'b0;
    d_alu_srca   = 1'b0;
    d_is_m       = 1'b0;
    d_mdu_f3     = 3'b000;
    legal        = 1'b1;
    case (op)
      7'b0000011: begin
        d_reg_wr = 1'b1; d_result_src = 2'b01; d_alu_src = 1'b1;
      end
      7'b0100011: begin
        d_mem_wr = 1'b1; d_alu_src = 1'b1; imm_srcD = IMM_SRC_W'(1);
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          d_reg_wr = 1'b1; d_alu_ctrl = alu_fn(funct3, funct7[5]);
        end else if (ENABLE_M != 0 && funct7 == 7'b0000001) begin
          d_reg_wr = 1'b1; d_result_src = 2'b11; d_is_m = 1'b1; d_mdu_f3 = funct3;
        end else begin
          legal = 1'b0;
        end
      end
      // funct7 is immediate bits here, so bit 5 only means arithmetic shift
      7'b0010011: begin
        d_reg_wr = 1'b1; d_alu_src = 1'b1;
        d_alu_ctrl = alu_fn(funct3, funct3 == 3'b101 && funct7[5]);
      end
      7'b1100011: begin
        d_branch = 1'b1; d_alu_ctrl = ALU_CTRL_W'(1); imm_srcD = IMM_SRC_W'(2);
      end
      7'b1101111: begin
        d_reg_wr = 1'b1; d_jump = 1'b1; d_result_src = 2'b10; imm_srcD = IMM_SRC_W'(3);
      end
      7'b1100111: begin
        if (funct3 == 3'b000) begin
          d_reg_wr = 1'b1; d_jump = 1'b1; d_jalr = 1'b1;
          d_result_src = 2'b10; d_alu_src = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      7'b0110111: begin
        d_reg_wr = 1'b1; d_alu_src = 1'b1; d_alu_ctrl = ALU_CTRL_W'(10);
        imm_srcD = IMM_SRC_W'(4);
      end
      7'b0010111: begin
        d_reg_wr = 1'b1; d_alu_src = 1'b1; d_alu_srca = 1'b1; imm_srcD = IMM_SRC_W'(4);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d_reg_wr = 1'b0; d_result_src = 2'b00; d_mem_wr = 1'b0; d_jump = 1'b0;
      d_jalr = 1'b0; d_branch = 1'b0; d_alu_ctrl = '0; d_alu_src = 1'b0;
      d_alu_srca = 1'b0; d_is_m = 1'b0; d_mdu_f3 = 3'b000;
    end
  end

  assign mdu_stall = (cnt_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wrE <= 1'b0; result_srcE <= 2'b00; mem_wrE <= 1'b0; jumpE <= 1'b0;
      jalrE <= 1'b0; branchE <= 1'b0; ALU_ctrlE <= '0; ALU_srcE <= 1'b0;
      ALU_srcAE <= 1'b0; illegalE <= 1'b0; mdu_startE <= 1'b0;
      mdu_funct3E <= 3'b000; cnt_reg <= '0;
    end else begin
      if (cnt_reg != '0)
        cnt_reg <= cnt_reg - 1'b1;
      if (mdu_stall) begin
        mdu_startE <= 1'b0;
      end else if (flushE || !validD) begin
        reg_wrE <= 1'b0; result_srcE <= 2'b00; mem_wrE <= 1'b0; jumpE <= 1'b0;
        jalrE <= 1'b0; branchE <= 1'b0; ALU_ctrlE <= '0; ALU_srcE <= 1'b0;
        ALU_srcAE <= 1'b0; illegalE <= 1'b0; mdu_startE <= 1'b0;
        mdu_funct3E <= 3'b000;
      end else begin
        reg_wrE <= d_reg_wr; result_srcE <= d_result_src; mem_wrE <= d_mem_wr;
        jumpE <= d_jump; jalrE <= d_jalr; branchE <= d_branch;
        ALU_ctrlE <= d_alu_ctrl; ALU_srcE <= d_alu_src; ALU_srcAE <= d_alu_srca;
        illegalE <= !legal; mdu_startE <= d_is_m; mdu_funct3E <= d_mdu_f3;
        if (d_is_m)
          cnt_reg <= CNT_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: expected E words queued at drive time, popped after the edge.
module tb_pipe_control_unit;

  typedef struct packed {
    logic       reg_wr;
    logic [1:0] res;
    logic       mem_wr, jump, jalr, branch;
    logic [3:0] alu;
    logic       src, srca, ill, start;
    logic [2:0] mf3;
    logic       stall;
  } ctrl_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic validD = 1'b0, flushE = 1'b0;
  logic [6:0] op = '0, funct7 = '0;
  logic [2:0] funct3 = '0;

  logic [2:0] imm_src, imm_src2;
  logic reg_wrE, mem_wrE, jumpE, jalrE, branchE, ALU_srcE, ALU_srcAE, illegalE, mdu_startE, mdu_stall;
  logic [1:0] result_srcE;
  logic [3:0] ALU_ctrlE;
  logic [2:0] mdu_funct3E;
  logic reg_wrE2, mem_wrE2, jumpE2, jalrE2, branchE2, ALU_srcE2, ALU_srcAE2, illegalE2, mdu_startE2, mdu_stall2;
  logic [1:0] result_srcE2;
  logic [3:0] ALU_ctrlE2;
  logic [2:0] mdu_funct3E2;

  ctrl_t obs, obs2;
  ctrl_t exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_control_unit #(.ALU_CTRL_W(4), .IMM_SRC_W(3), .ENABLE_M(1), .MDU_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .validD(validD), .op(op), .funct3(funct3), .funct7(funct7),
    .flushE(flushE), .imm_srcD(imm_src), .reg_wrE(reg_wrE), .result_srcE(result_srcE),
    .mem_wrE(mem_wrE), .jumpE(jumpE), .jalrE(jalrE), .branchE(branchE), .ALU_ctrlE(ALU_ctrlE),
    .ALU_srcE(ALU_srcE), .ALU_srcAE(ALU_srcAE), .illegalE(illegalE), .mdu_startE(mdu_startE),
    .mdu_funct3E(mdu_funct3E), .mdu_stall(mdu_stall));

  pipe_control_unit #(.ALU_CTRL_W(4), .IMM_SRC_W(3), .ENABLE_M(0), .MDU_CYCLES(4)) dut_nom (
    .clk(clk), .rst_n(rst_n), .validD(validD), .op(op), .funct3(funct3), .funct7(funct7),
    .flushE(flushE), .imm_srcD(imm_src2), .reg_wrE(reg_wrE2), .result_srcE(result_srcE2),
    .mem_wrE(mem_wrE2), .jumpE(jumpE2), .jalrE(jalrE2), .branchE(branchE2), .ALU_ctrlE(ALU_ctrlE2),
    .ALU_srcE(ALU_srcE2), .ALU_srcAE(ALU_srcAE2), .illegalE(illegalE2), .mdu_startE(mdu_startE2),
    .mdu_funct3E(mdu_funct3E2), .mdu_stall(mdu_stall2));

  assign obs  = {reg_wrE, result_srcE, mem_wrE, jumpE, jalrE, branchE, ALU_ctrlE,
                 ALU_srcE, ALU_srcAE, illegalE, mdu_startE, mdu_funct3E, mdu_stall};
  assign obs2 = {reg_wrE2, result_srcE2, mem_wrE2, jumpE2, jalrE2, branchE2, ALU_ctrlE2,
                 ALU_srcE2, ALU_srcAE2, illegalE2, mdu_startE2, mdu_funct3E2, mdu_stall2};

  function automatic ctrl_t cw(input logic rw, input logic [1:0] res, input logic mw,
                               input logic j, input logic jr, input logic br, input logic [3:0] alu,
                               input logic src, input logic srca, input logic ill,
                               input logic st, input logic [2:0] mf3, input logic stall);
    ctrl_t c;
    c = {rw, res, mw, j, jr, br, alu, src, srca, ill, st, mf3, stall};
    return c;
  endfunction

  task automatic cmp(input string tag, input ctrl_t got, input ctrl_t want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Drive one D instruction, check imm_srcD combinationally, then the E word after the edge.
  task automatic step(input string tag, input logic v, input logic [6:0] o, input logic [2:0] f3,
                      input logic [6:0] f7, input logic fl, input logic [2:0] imm_e, input ctrl_t e);
    ctrl_t want;
    @(negedge clk);
    validD = v; op = o; funct3 = f3; funct7 = f7; flushE = fl;
    exp_q.push_back(e);
    #1;
    checks++;
    assert (imm_src === imm_e) else begin
      errors++;
      $error("FAIL %s_imm observed=%b expected=%b", tag, imm_src, imm_e);
    end
    @(posedge clk); #1;
    want = exp_q.pop_front();
    cmp(tag, obs, want);
    $display("step %-10s E=%h stall=%b", tag, obs, mdu_stall);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_t ZERO, ADD, SUB, LW, SW, JALR, LUI, AUIPC, JAL, BEQ, ILL, SRAI, ADDI, MULS, MULH, MULE;
    ZERO  = '0;
    ADD   = cw(1, 2'b00, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 3'd0, 0);
    SUB   = cw(1, 2'b00, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0, 3'd0, 0);
    LW    = cw(1, 2'b01, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0, 3'd0, 0);
    SW    = cw(0, 2'b00, 1, 0, 0, 0, 4'd0, 1, 0, 0, 0, 3'd0, 0);
    JALR  = cw(1, 2'b10, 0, 1, 1, 0, 4'd0, 1, 0, 0, 0, 3'd0, 0);
    LUI   = cw(1, 2'b00, 0, 0, 0, 0, 4'd10, 1, 0, 0, 0, 3'd0, 0);
    AUIPC = cw(1, 2'b00, 0, 0, 0, 0, 4'd0, 1, 1, 0, 0, 3'd0, 0);
    JAL   = cw(1, 2'b10, 0, 1, 0, 0, 4'd0, 0, 0, 0, 0, 3'd0, 0);
    BEQ   = cw(0, 2'b00, 0, 0, 0, 1, 4'd1, 0, 0, 0, 0, 3'd0, 0);
    ILL   = cw(0, 2'b00, 0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 3'd0, 0);
    SRAI  = cw(1, 2'b00, 0, 0, 0, 0, 4'd9, 1, 0, 0, 0, 3'd0, 0);
    ADDI  = cw(1, 2'b00, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0, 3'd0, 0);
    MULS  = cw(1, 2'b11, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 3'd2, 1);
    MULH  = cw(1, 2'b11, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 3'd2, 1);
    MULE  = cw(1, 2'b11, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 3'd2, 0);

    repeat (2) @(negedge clk);
    #1;
    cmp("reset", obs, ZERO);
    @(negedge clk);
    rst_n = 1'b1;

    step("add",   1, 7'b0110011, 3'b000, 7'b0000000, 0, 3'b000, ADD);
    step("sub",   1, 7'b0110011, 3'b000, 7'b0100000, 0, 3'b000, SUB);
    step("lw",    1, 7'b0000011, 3'b010, 7'b0000000, 0, 3'b000, LW);
    step("sw",    1, 7'b0100011, 3'b010, 7'b0000000, 0, 3'b001, SW);
    step("jalr",  1, 7'b1100111, 3'b000, 7'b0000000, 0, 3'b000, JALR);
    step("lui",   1, 7'b0110111, 3'b101, 7'b0010101, 0, 3'b100, LUI);
    step("auipc", 1, 7'b0010111, 3'b011, 7'b1000000, 0, 3'b100, AUIPC);
    step("jal",   1, 7'b1101111, 3'b000, 7'b0000000, 0, 3'b011, JAL);
    step("beqfl", 1, 7'b1100011, 3'b000, 7'b0000000, 1, 3'b010, ZERO);
    step("beq",   1, 7'b1100011, 3'b000, 7'b0000000, 0, 3'b010, BEQ);
    step("novld", 0, 7'b0110011, 3'b000, 7'b0000000, 0, 3'b000, ZERO);
    step("illop", 1, 7'b1111111, 3'b000, 7'b0000000, 0, 3'b000, ILL);
    step("srai",  1, 7'b0010011, 3'b101, 7'b0100000, 0, 3'b000, SRAI);
    step("addi7", 1, 7'b0010011, 3'b000, 7'b0100000, 0, 3'b000, ADDI);

    step("mul",   1, 7'b0110011, 3'b010, 7'b0000001, 0, 3'b000, MULS);
    cmp("nom_mul", obs2, ILL);
    step("hold1", 1, 7'b0110011, 3'b000, 7'b0000000, 0, 3'b000, MULH);
    cmp("nom_add", obs2, ADD);
    step("hold2", 1, 7'b0110011, 3'b000, 7'b0000000, 1, 3'b000, MULH);
    step("hold3", 1, 7'b0110011, 3'b000, 7'b0000000, 0, 3'b000, MULE);
    step("addm",  1, 7'b0110011, 3'b000, 7'b0000000, 0, 3'b000, ADD);

    step("mul2",  1, 7'b0110011, 3'b010, 7'b0000001, 0, 3'b000, MULS);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst", obs, ZERO);
    validD = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("postrst", 1, 7'b0110011, 3'b000, 7'b0100000, 0, 3'b000, SUB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
